cast_sequencer: RTL



---
 rtl/cast_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cast_sequencer.sv
// cast_sequencer: streams a job of cfg_num elements through an external combinational cast unit.
// Define CAST_SEQ_PERF_CNT_EN to add the stall_cycles / job_cycles performance counters.
module cast_sequencer #(
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int LEN_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [FUNCTION_BITS-1:0] cfg_fn,
  input  logic [31:0]              cfg_imm,
  input  logic [LEN_BITS-1:0]      cfg_num,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     out_data,
  output logic [FUNCTION_BITS-1:0] cast_fn,
  output logic [31:0]              cast_imm,
  output logic [BIT_WIDTH-1:0]     cast_din,
  input  logic [BIT_WIDTH-1:0]     cast_dout
`ifdef CAST_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              job_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [FUNCTION_BITS-1:0]   fn_q, fn_d;
  logic [31:0]                imm_q, imm_d;
  logic [LEN_BITS-1:0]        remaining_q, remaining_d;
  logic                       out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0]       out_data_q, out_data_d;
  logic                       done_q, done_d;
  logic                       cfg_err_q, cfg_err_d;

  logic fn_legal;
  logic start_accept;
  logic in_hs;
  logic out_hs;

  assign fn_legal = (cfg_fn <= FUNCTION_BITS'(5)) ||
                    (cfg_fn == FUNCTION_BITS'(8)) ||
                    (cfg_fn == FUNCTION_BITS'(9));

  assign start_accept = (state_q == IDLE) && start && fn_legal;

  assign in_ready = (state_q == RUN) && (remaining_q != '0) && (!out_valid_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    fn_d        = fn_q;
    imm_d       = imm_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;

    // A push in the same cycle as a pop refills the output register, keeping one element per cycle.
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = cast_dout;
      remaining_d = remaining_q - LEN_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (fn_legal) begin
            fn_d        = cfg_fn;
            imm_d       = cfg_imm;
            remaining_d = cfg_num;
            cfg_err_d   = 1'b0;
            state_d     = (cfg_num == '0) ? DRAIN : RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (remaining_d == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fn_q        <= '0;
      imm_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fn_q        <= fn_d;
      imm_q       <= imm_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cast_fn   = fn_q;
  assign cast_imm  = imm_q;
  assign cast_din  = in_data;

`ifdef CAST_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] job_cycles_q, job_cycles_d;

  // Counters restart with each accepted job and freeze once it completes.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    job_cycles_d   = job_cycles_q;
    if (start_accept) begin
      stall_cycles_d = '0;
      job_cycles_d   = '0;
    end else if (busy) begin
      job_cycles_d = job_cycles_q + 32'd1;
      if (out_valid_q && !out_ready) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      job_cycles_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      job_cycles_q   <= job_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign job_cycles   = job_cycles_q;
`endif

endmodule
